pipeline_step_ctrl: RTL
=======================

Name: pipeline_step_ctrl

Overview:
- Sequences the five-stage MIPS pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) for the debug unit.
- Generates the global latch enable o_step, which drives every latch's i_step.
- Supports free-run, N-cycle stepping, pause, and halt detection via the stop_pipe flag leaving MEM/WB.
- Sits between the UART debug command decoder and the pipeline top; also provides a one-cycle pipeline flush and a cycle counter for reporting.

Parameters:
- CNT_W, 32, width of executed-cycle counter o_cycles
- ARG_W, 8, width of step-count argument i_cmd_arg

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- i_cmd_valid  in  1  command strobe from debug decoder
- i_cmd  in  2  command: 00 CLEAR, 01 RUN, 10 STEP, 11 PAUSE
- i_cmd_arg  in  ARG_W  step count for STEP; 0 treated as 1
- i_stop_pipe  in  1  os_stop_pipe from MEM/WB latch (HALT reached writeback)
- i_pc  in  32  PC of instruction in ID/EX (used only with breakpoint feature)
- o_cmd_ready  out  1  constant 1 after reset; commands are never back-pressured
- o_cmd_err  out  1  one-cycle pulse: command illegal in current state, dropped
- o_step  out  1  latch enable to all pipeline latches
- o_flush  out  1  one-cycle pulse, OR'd into latch clears (rst path) by top
- o_done  out  1  high while in HALTED
- o_state  out  2  current state encoding, for debug readback
- o_cycles  out  CNT_W  count of cycles with o_step=1, saturating

Behaviour:
- Reset (rst=0 at posedge): state=IDLE; rem=0; o_step=0, o_flush=0, o_done=0, o_cmd_err=0, o_cycles=0, o_state=00. o_cmd_ready=0 during reset, 1 otherwise.
- States: IDLE=00, RUN=01, STEP=10, HALTED=11. o_step is a Moore decode: 1 iff state in {RUN, STEP}. o_done=1 iff HALTED.
- A command is accepted on a posedge with i_cmd_valid=1. Effects appear the next cycle.
- IDLE:
  - RUN -> RUN.
  - STEP -> STEP with rem := (arg==0 ? 1 : arg).
  - CLEAR -> o_flush=1 next cycle, o_cycles:=0, stay IDLE.
  - PAUSE -> o_cmd_err pulse.
- RUN:
  - i_stop_pipe=1 -> HALTED. This has priority over any command in the same cycle.
  - else PAUSE -> IDLE.
  - RUN/STEP/CLEAR -> o_cmd_err pulse, stay RUN.
- STEP:
  - Each cycle rem decrements.
  - i_stop_pipe=1 -> HALTED (highest priority).
  - else PAUSE -> IDLE.
  - else rem==1 -> IDLE.
  - Other commands -> o_cmd_err.
  - Exactly max(arg,1) cycles of o_step=1 per STEP command when uninterrupted.
- HALTED:
  - Only CLEAR is legal: o_flush pulse, o_cycles:=0, -> IDLE.
  - Others -> o_cmd_err.
  - o_step=0, so the pipeline is frozen with HALT in writeback.
- i_stop_pipe is ignored in IDLE and HALTED. It is only sampled while o_step=1; the cycle on which it is sampled still has o_step=1.
- o_cycles increments by 1 on every posedge where o_step=1. It holds at all-ones and never wraps.
- o_flush and o_cmd_err are registered, one cycle wide, and never asserted together.
- Reset mid-RUN/STEP drops to IDLE immediately. rem is discarded and no flush pulse is issued (the reset itself clears the latches).
- Simultaneous stop_pipe and rem==1 in STEP -> HALTED.

Optional Feature:
- Macro STEP_CTRL_BKPT_EN.
- When defined:
  - Adds input i_bkpt_addr (32) and i_bkpt_en (1).
  - In RUN, if i_bkpt_en=1 and i_pc==i_bkpt_addr while o_step=1, next state is IDLE (pause).
  - Priority: stop_pipe > breakpoint > command.
  - A subsequent RUN ignores the match for the first cycle, so execution can resume past the breakpoint.
  - STEP is unaffected by breakpoints.
- When undefined: the ports are absent and i_pc is unused.

Test Plan:
- Reset, then STEP arg=3 -> o_step high exactly 3 cycles starting next cycle; back to IDLE; o_cycles=3.
- STEP arg=0 -> o_step high exactly 1 cycle; o_cycles increments by 1.
- RUN, then i_stop_pipe=1 on the 10th step cycle -> o_step drops the next cycle, o_done=1, o_cycles=10. A following RUN produces an o_cmd_err pulse with no state change.
- From HALTED, CLEAR -> one-cycle o_flush, o_cycles=0, state IDLE. PAUSE in IDLE -> o_cmd_err pulse.
- RUN, then PAUSE on the same posedge as i_stop_pipe=1 -> HALTED, no o_cmd_err. RUN, then rst=0 mid-run -> IDLE, o_step=0, o_cycles=0, no o_flush.
- With STEP_CTRL_BKPT_EN: bkpt=0x20, RUN from PC 0 -> pause when i_pc=0x20. RUN again -> continues past 0x20 without re-pausing.

Source files
------------

// File: rtl/pipeline_step_ctrl_if.sv
// Command channel between the UART debug command decoder and pipeline_step_ctrl.
//
// Handshake: the decoder (master) raises i_cmd_valid for one or more cycles
// with i_cmd/i_cmd_arg stable. A command transfers on every posedge where
// i_cmd_valid && o_cmd_ready. The controller (slave) holds o_cmd_ready high
// at all times outside reset, so it never back-pressures. A command that is
// illegal in the current state is dropped, and a one-cycle o_cmd_err pulse
// follows on the next cycle.
//
// Signals:
//   i_cmd_valid  decoder -> ctrl  command strobe
//   i_cmd        decoder -> ctrl  00 CLEAR, 01 RUN, 10 STEP, 11 PAUSE
//   i_cmd_arg    decoder -> ctrl  step count for STEP (0 treated as 1)
//   o_cmd_ready  ctrl -> decoder  1 outside reset
//   o_cmd_err    ctrl -> decoder  one-cycle pulse, command dropped
interface pipeline_step_ctrl_if #(
  parameter int ARG_W = 8
);
  logic             i_cmd_valid;
  logic [1:0]       i_cmd;
  logic [ARG_W-1:0] i_cmd_arg;
  logic             o_cmd_ready;
  logic             o_cmd_err;

  modport master (
    output i_cmd_valid, i_cmd, i_cmd_arg,
    input  o_cmd_ready, o_cmd_err
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_cmd_arg,
    output o_cmd_ready, o_cmd_err
  );
endinterface

// File: rtl/pipeline_step_ctrl.sv
// Pipeline step controller for the MIPS debug unit.
//
// Produces the global latch enable o_step that drives every pipeline latch
// (IF/ID, ID/EX, EX/MEM, MEM/WB). Supports free-run, N-cycle stepping,
// pause, halt detection via the stop_pipe flag leaving MEM/WB, a one-cycle
// flush pulse and a saturating count of executed (stepped) cycles.
//
// Optional feature: define STEP_CTRL_BKPT_EN to add a PC breakpoint that
// pauses a RUN when the ID/EX PC matches i_bkpt_addr.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-low
//   cmd          command channel (slave modport of pipeline_step_ctrl_if)
//   i_stop_pipe  HALT has reached writeback (from MEM/WB latch)
//   i_pc         PC of the instruction in ID/EX (breakpoint feature only)
//   i_bkpt_addr  breakpoint address   (STEP_CTRL_BKPT_EN only)
//   i_bkpt_en    breakpoint enable    (STEP_CTRL_BKPT_EN only)
//   o_step       latch enable to all pipeline latches
//   o_flush      one-cycle pulse, OR'd into the latch clears by the top
//   o_done       high while HALTED
//   o_state      state encoding: IDLE=00 RUN=01 STEP=10 HALTED=11
//   o_cycles     count of cycles with o_step=1, saturating
module pipeline_step_ctrl #(
  parameter int CNT_W = 32,
  parameter int ARG_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  pipeline_step_ctrl_if.slave cmd,
  input  logic                i_stop_pipe,
  input  logic [31:0]         i_pc,
`ifdef STEP_CTRL_BKPT_EN
  input  logic [31:0]         i_bkpt_addr,
  input  logic                i_bkpt_en,
`endif
  output logic                o_step,
  output logic                o_flush,
  output logic                o_done,
  output logic [1:0]          o_state,
  output logic [CNT_W-1:0]    o_cycles
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_PAUSE = 2'b11;

  state_t           state;
  logic [ARG_W-1:0] rem;
  logic             ready_q;
  logic             err_q;
  logic             accept;
  logic             bkpt_hit;

  assign accept = cmd.i_cmd_valid && ready_q;

`ifdef STEP_CTRL_BKPT_EN
  // First RUN cycle after a RUN command ignores the match so execution can
  // resume from a PC that is sitting on the breakpoint.
  logic bkpt_skip;
  assign bkpt_hit = i_bkpt_en && (i_pc == i_bkpt_addr) && !bkpt_skip;
`else
  logic unused_pc;
  assign unused_pc = ^i_pc;
  assign bkpt_hit  = 1'b0;
`endif

  // Moore decodes straight from the state register.
  assign o_step          = (state == S_RUN) || (state == S_STEP);
  assign o_done          = (state == S_HALTED);
  assign o_state         = state;
  assign cmd.o_cmd_ready = ready_q;
  assign cmd.o_cmd_err   = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      rem      <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      o_flush  <= 1'b0;
      o_cycles <= '0;
`ifdef STEP_CTRL_BKPT_EN
      bkpt_skip <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b1;
      err_q   <= 1'b0;
      o_flush <= 1'b0;

      if (o_step && (o_cycles != {CNT_W{1'b1}}))
        o_cycles <= o_cycles + 1'b1;

      case (state)
        S_IDLE: begin
          if (accept) begin
            case (cmd.i_cmd)
              CMD_CLEAR: begin
                o_flush  <= 1'b1;
                o_cycles <= '0;
              end
              CMD_RUN: begin
                state <= S_RUN;
`ifdef STEP_CTRL_BKPT_EN
                bkpt_skip <= 1'b1;
`endif
              end
              CMD_STEP: begin
                state <= S_STEP;
                rem   <= (cmd.i_cmd_arg == '0) ? ARG_W'(1) : cmd.i_cmd_arg;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end

        S_RUN: begin
`ifdef STEP_CTRL_BKPT_EN
          bkpt_skip <= 1'b0;
`endif
          // stop_pipe > breakpoint > command; a command that loses to a
          // halt or breakpoint is simply dropped without an error pulse.
          if (i_stop_pipe)
            state <= S_HALTED;
          else if (bkpt_hit)
            state <= S_IDLE;
          else if (accept) begin
            if (cmd.i_cmd == CMD_PAUSE)
              state <= S_IDLE;
            else
              err_q <= 1'b1;
          end
        end

        S_STEP: begin
          rem <= rem - 1'b1;
          if (i_stop_pipe)
            state <= S_HALTED;
          else if (accept && (cmd.i_cmd == CMD_PAUSE))
            state <= S_IDLE;
          else begin
            if (accept)
              err_q <= 1'b1;
            if (rem == ARG_W'(1))
              state <= S_IDLE;
          end
        end

        S_HALTED: begin
          if (accept) begin
            if (cmd.i_cmd == CMD_CLEAR) begin
              o_flush  <= 1'b1;
              o_cycles <= '0;
              state    <= S_IDLE;
            end else
              err_q <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
